// File: rtl/lpc_synth_decoder.sv
// lpc_synth_decoder: parametrised all-pole LPC synthesis filter with serial MAC, bypass, saturation and frame checking
module lpc_synth_decoder #(
  parameter int ORDER     = 4,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int FRAC      = 14,
  parameter int FRAME_LEN = 1920
) (
  input  logic                           ACLK,
  input  logic                           ARESET_N,
  input  logic [DATA_W+ORDER*COEF_W-1:0] TDATA,
  input  logic                           TVALID,
  output logic                           TREADY,
  input  logic                           TLAST,
  input  logic                           TUSER,
  input  logic                           EN,
  output logic [DATA_W-1:0]              OUT_DECODED,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic                           OUT_LAST,
  output logic                           FRAME_ERR
);
  localparam int AW = DATA_W + COEF_W + $clog2(ORDER) + 2;
  localparam int KW = ORDER > 1 ? $clog2(ORDER) : 1;
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic signed [AW-1:0] MAXV = (AW'(1) <<< (DATA_W - 1)) - AW'(1);
  localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
  state_t r_state, w_next;
  logic r_alive, r_last, r_ferr;
  logic [KW-1:0] r_k;
  logic [CW-1:0] r_cnt;
  logic signed [AW-1:0] r_acc;
  logic [ORDER*COEF_W-1:0] r_coef;
  logic signed [DATA_W-1:0] r_hist [ORDER];
  logic signed [DATA_W-1:0] r_out;
  logic w_acc, w_done, w_full;
  logic [CW-1:0] w_cnt1;
  logic signed [DATA_W-1:0] w_res, w_y;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [DATA_W+COEF_W-1:0] w_prod;
  logic signed [AW-1:0] w_sum, w_sh;
  assign TREADY      = r_alive && r_state == IDLE;
  assign OUT_VALID   = r_state == OUT;
  assign OUT_DECODED = r_out;
  assign OUT_LAST    = r_last;
  assign FRAME_ERR   = r_ferr;
  assign w_acc  = TREADY && TVALID;
  assign w_done = r_state == CALC && r_k == KW'(ORDER - 1);
  assign w_res  = TDATA[DATA_W-1:0];
  assign w_coef = r_coef[r_k*COEF_W +: COEF_W];
  assign w_prod = w_coef * r_hist[r_k];
  assign w_sum  = r_acc + AW'(w_prod);
  assign w_sh   = w_sum >>> FRAC;
  assign w_y    = w_sh > MAXV ? DATA_W'(MAXV) : w_sh < MINV ? DATA_W'(MINV) : w_sh[DATA_W-1:0];
  assign w_cnt1 = (TUSER ? '0 : r_cnt) + 1'b1;
  assign w_full = w_cnt1 == CW'(FRAME_LEN);
  always_ff @(posedge ACLK or negedge ARESET_N)
    if (!ARESET_N) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_acc ? (EN ? CALC : OUT) : IDLE) :
             r_state == CALC ? (w_done ? OUT : CALC) :
             (OUT_READY ? IDLE : OUT);
  end
  always_ff @(posedge ACLK or negedge ARESET_N)
    if (!ARESET_N) begin
      r_alive <= 1'b0;
      r_last  <= 1'b0;
      r_ferr  <= 1'b0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_coef  <= '0;
      r_out   <= '0;
      for (int i = 0; i < ORDER; i++) r_hist[i] <= '0;
    end else begin
      r_alive <= 1'b1;
      r_ferr  <= 1'b0;
      if (w_acc) begin
        r_coef <= TDATA[DATA_W +: ORDER*COEF_W];
        r_last <= TLAST;
        r_k    <= '0;
        r_acc  <= (AW'(w_res) <<< FRAC) + (AW'(1) <<< (FRAC - 1));
        r_ferr <= TLAST ? w_cnt1 != CW'(FRAME_LEN) : w_full;
        r_cnt  <= (TLAST || w_full) ? '0 : w_cnt1;
        // bypass still feeds the history so a later EN=1 word sees it
        if (!EN) begin
          r_out     <= w_res;
          r_hist[0] <= w_res;
          for (int i = 1; i < ORDER; i++) r_hist[i] <= TUSER ? '0 : r_hist[i-1];
        end else if (TUSER)
          for (int i = 0; i < ORDER; i++) r_hist[i] <= '0;
      end else if (r_state == CALC) begin
        r_acc <= w_sum;
        r_k   <= r_k + 1'b1;
        if (w_done) begin
          r_out     <= w_y;
          r_hist[0] <= w_y;
          for (int i = 1; i < ORDER; i++) r_hist[i] <= r_hist[i-1];
        end
      end
    end
endmodule

// File: tb/tb_lpc_synth_decoder.sv
// tb_lpc_synth_decoder: randomized scoreboard bench for lpc_synth_decoder against an arithmetic reference model
module tb_lpc_synth_decoder;
  localparam int ORDER = 4, DW = 16, CW = 16, FRAC = 14, FL = 4;
  logic ACLK = 0, ARESET_N = 0;
  logic [DW+ORDER*CW-1:0] TDATA = '0;
  logic TVALID = 0, TLAST = 0, TUSER = 0, EN = 0, OUT_READY = 1;
  logic TREADY, OUT_VALID, OUT_LAST, FRAME_ERR;
  logic [DW-1:0] OUT_DECODED;
  int n_chk = 0, n_fail = 0;
  int exp_y[$];
  bit exp_l[$];
  bit exp_ferr = 0, rnd_rdy = 0;
  int mh[ORDER];
  int fcnt = 0;

  lpc_synth_decoder #(.ORDER(ORDER), .DATA_W(DW), .COEF_W(CW), .FRAC(FRAC), .FRAME_LEN(FL)) dut (
    .ACLK(ACLK), .ARESET_N(ARESET_N), .TDATA(TDATA), .TVALID(TVALID), .TREADY(TREADY),
    .TLAST(TLAST), .TUSER(TUSER), .EN(EN), .OUT_DECODED(OUT_DECODED), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST), .FRAME_ERR(FRAME_ERR));

  always #5 ACLK = ~ACLK;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: y[n] = sat(floor((r*2^FRAC + sum a_k*y[n-k] + 2^(FRAC-1)) / 2^FRAC))
  task automatic model(input int r, input int a[ORDER], input bit tuser, input bit last, input bit en, output bit err);
    longint acc;
    int y, n;
    if (tuser) foreach (mh[i]) mh[i] = 0;
    if (!en) y = r;
    else begin
      acc = longint'(r) * (longint'(1) << FRAC) + (longint'(1) << (FRAC - 1));
      for (int k = 0; k < ORDER; k++) acc += longint'(a[k]) * mh[k];
      acc = acc >>> FRAC;
      y = acc > 32767 ? 32767 : acc < -32768 ? -32768 : int'(acc);
    end
    for (int i = ORDER - 1; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = y;
    exp_y.push_back(y);
    exp_l.push_back(last);
    n = (tuser ? 0 : fcnt) + 1;
    if (last) begin err = n != FL; fcnt = 0; end
    else if (n == FL) begin err = 1; fcnt = 0; end
    else begin err = 0; fcnt = n; end
  endtask

  task automatic send(input int r, input int a[ORDER], input bit tuser, input bit last, input bit en);
    bit ok = 0, err;
    int t;
    @(posedge ACLK); #1;
    TDATA[DW-1:0] = r[DW-1:0];
    for (int k = 0; k < ORDER; k++) begin t = a[k]; TDATA[DW+k*CW +: CW] = t[CW-1:0]; end
    TUSER = tuser; TLAST = last; EN = en; TVALID = 1;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge ACLK); ok = TREADY; end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: got TREADY=0 expected 1 within 300 cycles");
      TVALID = 0;
      return;
    end
    @(posedge ACLK);
    model(r, a, tuser, last, en, err);
    exp_ferr = err;
    #1;
    TVALID = 0;
    TDATA = {$urandom, $urandom, $urandom};
    TUSER = $urandom_range(0, 1); TLAST = $urandom_range(0, 1); EN = $urandom_range(0, 1);
  endtask

  task automatic lat(input int exp_n);
    int n = 0;
    do begin @(negedge ACLK); n++; end while (!OUT_VALID && n < 20);
    chk("latency", n, exp_n);
    chk("tready_busy", TREADY, 0);
    @(negedge ACLK);
    chk("tready_reassert", TREADY, 1);
  endtask

  task automatic dsend(input int r, input int a1, input bit tuser, input bit last, input bit en);
    int a[ORDER];
    foreach (a[i]) a[i] = 0;
    a[0] = a1;
    send(r, a, tuser, last, en);
    lat(en ? ORDER + 1 : 1);
  endtask

  task automatic monitor();
    forever begin
      @(negedge ACLK);
      if (ARESET_N) begin
        chk("frame_err", FRAME_ERR, exp_ferr);
        exp_ferr = 0;
        if (OUT_VALID && OUT_READY) begin
          if (exp_y.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_sample: got %0d expected none", $signed(OUT_DECODED));
          end else begin
            chk("sample", longint'($signed(OUT_DECODED)), exp_y.pop_front());
            chk("out_last", OUT_LAST, exp_l.pop_front());
          end
        end
      end
    end
  endtask

  task automatic rnd_ready();
    forever begin
      @(posedge ACLK); #1;
      if (rnd_rdy) OUT_READY = $urandom_range(0, 1);
    end
  endtask

  initial begin
    int a[ORDER];
    int hold, n;
    foreach (mh[i]) mh[i] = 0;
    fork
      monitor();
      rnd_ready();
    join_none
    #2;
    chk("rst_tready", TREADY, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_data", OUT_DECODED, 0);
    chk("rst_last", OUT_LAST, 0);
    chk("rst_ferr", FRAME_ERR, 0);
    repeat (3) @(negedge ACLK);
    ARESET_N = 1;
    @(negedge ACLK);
    chk("tready_after_rst", TREADY, 1);
    // impulse through a1 = 0.5
    dsend(1000, 8192, 1, 0, 1);
    repeat (4) dsend(0, 8192, 0, 0, 1);
    // saturation both rails
    dsend(30000, 16384, 1, 0, 1);
    dsend(30000, 16384, 0, 0, 1);
    dsend(-30000, 16384, 1, 0, 1);
    dsend(-30000, 16384, 0, 0, 1);
    // bypass then filter reusing bypassed history
    dsend(-123, 0, 0, 0, 0);
    dsend(0, 16384, 0, 0, 1);
    // framing: good frame of 4, then short frame of 3
    dsend(5, 0, 1, 0, 1);
    dsend(6, 0, 0, 0, 1);
    dsend(7, 0, 0, 0, 0);
    dsend(8, 0, 0, 1, 1);
    dsend(9, 0, 0, 0, 1);
    dsend(10, 0, 0, 0, 0);
    dsend(11, 0, 0, 1, 1);
    // backpressure
    OUT_READY = 0;
    foreach (a[i]) a[i] = 4000 - 3000 * i;
    send(2222, a, 0, 0, 1);
    n = 0;
    while (!OUT_VALID && n < 20) begin @(negedge ACLK); n++; end
    hold = OUT_DECODED;
    repeat (5) begin
      @(negedge ACLK);
      chk("bp_stable", OUT_DECODED, hold);
      chk("bp_valid", OUT_VALID, 1);
      chk("bp_tready", TREADY, 0);
    end
    @(posedge ACLK); #1;
    OUT_READY = 1;
    repeat (3) @(negedge ACLK);
    // asynchronous reset in CALC discards the sample
    foreach (a[i]) a[i] = 0;
    a[0] = 8192;
    send(777, a, 0, 0, 1);
    @(posedge ACLK); #1;
    ARESET_N = 0;
    #1;
    chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_data", OUT_DECODED, 0);
    chk("mid_rst_last", OUT_LAST, 0);
    chk("mid_rst_ferr", FRAME_ERR, 0);
    chk("mid_rst_tready", TREADY, 0);
    void'(exp_y.pop_back());
    void'(exp_l.pop_back());
    foreach (mh[i]) mh[i] = 0;
    fcnt = 0;
    exp_ferr = 0;
    @(negedge ACLK);
    ARESET_N = 1;
    @(negedge ACLK);
    chk("tready_after_mid_rst", TREADY, 1);
    dsend(1000, 8192, 0, 0, 1);
    // randomized traffic with random backpressure
    rnd_rdy = 1;
    for (int w = 0; w < 100; w++) begin
      foreach (a[i]) a[i] = (w % 3 == 0) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 8191)) - 4096;
      send(int'($urandom_range(0, 65535)) - 32768, a, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 2)) @(posedge ACLK);
    end
    rnd_rdy = 0;
    @(posedge ACLK); #1;
    OUT_READY = 1;
    n = 0;
    while (exp_y.size() != 0 && n < 100) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    chk("drain", exp_y.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
